// File: rtl/exc_flush_ctrl.sv
// Exception/ertn sequencer at WB: commit pulse in T+1, flush for 1+DRAIN_CYCLES cycles,
// then redirect held until redirect_ready. Define INT_SAMPLE_EN to take pending interrupts at WB.
module exc_flush_ctrl #(
   parameter int         DRAIN_CYCLES = 2,
   parameter logic [5:0] ECODE_INT    = 6'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_valid,
   input  logic        wb_ex,
   input  logic [5:0]  wb_ecode,
   input  logic [8:0]  wb_esubcode,
   input  logic        wb_ertn,
   input  logic [31:0] wb_pc,
   input  logic [31:0] csr_eentry,
   input  logic [31:0] csr_era,
   input  logic        int_pending,
   input  logic        redirect_ready,
   output logic        wb_cancel,
   output logic        csr_ex_commit,
   output logic        csr_ertn_commit,
   output logic [5:0]  csr_ecode,
   output logic [8:0]  csr_esubcode,
   output logic [31:0] csr_era_wdata,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_DRAIN, S_REDIRECT} state_t;

   state_t      state, state_nxt;
   logic        kind_ex;
   logic [3:0]  drain_cnt;
   logic        take_ex, take_ertn, take_int, ev;

   assign take_ex   = wb_valid && wb_ex;
   assign take_ertn = wb_valid && !wb_ex && wb_ertn;
`ifdef INT_SAMPLE_EN
   assign take_int  = wb_valid && !wb_ex && !wb_ertn && int_pending;
`else
   logic unused_int_pending;
   assign take_int           = 1'b0;
   assign unused_int_pending = int_pending;
`endif
   assign ev = take_ex || take_ertn || take_int;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt       = state;
      wb_cancel       = 1'b0;
      csr_ex_commit   = 1'b0;
      csr_ertn_commit = 1'b0;
      flush           = 1'b0;
      redirect_valid  = 1'b0;
      busy            = 1'b0;
      case (state)
         S_IDLE: begin
            // Interrupts let the WB instruction commit, so only a real exception cancels it.
            wb_cancel = take_ex;
            if (ev) state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            flush           = 1'b1;
            busy            = 1'b1;
            csr_ex_commit   = kind_ex;
            csr_ertn_commit = !kind_ex;
            state_nxt       = (DRAIN_CYCLES > 0) ? S_DRAIN : S_REDIRECT;
         end
         S_DRAIN: begin
            flush = 1'b1;
            busy  = 1'b1;
            if (drain_cnt <= 4'd1) state_nxt = S_REDIRECT;
         end
         S_REDIRECT: begin
            redirect_valid = 1'b1;
            busy           = 1'b1;
            if (redirect_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         kind_ex       <= 1'b0;
         csr_ecode     <= 6'h00;
         csr_esubcode  <= 9'h000;
         csr_era_wdata <= 32'h0;
         redirect_pc   <= 32'h0;
         drain_cnt     <= 4'd0;
      end else begin
         if (state == S_IDLE && ev) begin
            kind_ex       <= take_ex || take_int;
            csr_ecode     <= take_int ? ECODE_INT : wb_ecode;
            csr_esubcode  <= take_int ? 9'h000 : wb_esubcode;
            csr_era_wdata <= take_int ? (wb_pc + 32'd4) : wb_pc;
         end
         if (state == S_FLUSH) begin
            redirect_pc <= kind_ex ? csr_eentry : csr_era;
            drain_cnt   <= 4'(DRAIN_CYCLES);
         end else if (state == S_DRAIN) begin
            drain_cnt <= drain_cnt - 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// Directed bench for exc_flush_ctrl with DRAIN_CYCLES=2; INT_SAMPLE_EN selects the interrupt expectations.
module tb_exc_flush_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_valid, wb_ex, wb_ertn, int_pending, redirect_ready;
   logic [5:0]  wb_ecode;
   logic [8:0]  wb_esubcode;
   logic [31:0] wb_pc, csr_eentry, csr_era;
   logic        wb_cancel, csr_ex_commit, csr_ertn_commit, flush, redirect_valid, busy;
   logic [5:0]  csr_ecode;
   logic [8:0]  csr_esubcode;
   logic [31:0] csr_era_wdata, redirect_pc;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   exc_flush_ctrl #(.DRAIN_CYCLES(2), .ECODE_INT(6'h00)) dut (
      .clk(clk), .reset(reset),
      .wb_valid(wb_valid), .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
      .wb_ertn(wb_ertn), .wb_pc(wb_pc), .csr_eentry(csr_eentry), .csr_era(csr_era),
      .int_pending(int_pending), .redirect_ready(redirect_ready),
      .wb_cancel(wb_cancel), .csr_ex_commit(csr_ex_commit), .csr_ertn_commit(csr_ertn_commit),
      .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode), .csr_era_wdata(csr_era_wdata),
      .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
   );

   // Outputs are sampled 1 time unit after the rising edge; inputs change right after.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_wb;
      wb_valid    = 1'b0;
      wb_ex       = 1'b0;
      wb_ertn     = 1'b0;
      int_pending = 1'b0;
      wb_ecode    = 6'h00;
      wb_esubcode = 9'h000;
      wb_pc       = 32'h0;
   endtask

   // {ex_commit, ertn_commit, flush, redirect_valid, busy}
   task automatic test_reset;
      clear_wb();
      reset = 1'b1; redirect_ready = 1'b0;
      csr_eentry = 32'h0; csr_era = 32'h0;
      tick(); tick();
      reset = 1'b0;
      #1;
      total++;
      if ({csr_ex_commit, csr_ertn_commit, flush, redirect_valid, busy, wb_cancel} !== 6'b0)
         $display("FAIL reset_ctrl: got %b expected 000000",
                  {csr_ex_commit, csr_ertn_commit, flush, redirect_valid, busy, wb_cancel});
      else passed++;
      total++;
      if ({csr_ecode, csr_esubcode, csr_era_wdata, redirect_pc} !== 79'h0)
         $display("FAIL reset_data: got %h expected 0",
                  {csr_ecode, csr_esubcode, csr_era_wdata, redirect_pc});
      else passed++;
   endtask

   task automatic test_syscall;
      clear_wb();
      redirect_ready = 1'b0;
      csr_eentry = 32'h1c008000; csr_era = 32'h1c0000f0;
      wb_valid = 1'b1; wb_ex = 1'b1; wb_ecode = 6'h0b; wb_esubcode = 9'h001; wb_pc = 32'h1c000100;
      #1;
      total++;
      if ({wb_cancel, busy} !== 2'b10) $display("FAIL sys_T_cancel: got %b expected 10", {wb_cancel, busy});
      else passed++;
      tick(); clear_wb(); #1;                                   // T+1
      total++;
      if ({csr_ex_commit, csr_ertn_commit, flush, redirect_valid, busy} !== 5'b10101)
         $display("FAIL sys_T1_ctrl: got %b expected 10101",
                  {csr_ex_commit, csr_ertn_commit, flush, redirect_valid, busy});
      else passed++;
      total++;
      if ({csr_ecode, csr_esubcode, csr_era_wdata} !== {6'h0b, 9'h001, 32'h1c000100})
         $display("FAIL sys_T1_data: got %h/%h/%h expected 0b/001/1c000100",
                  csr_ecode, csr_esubcode, csr_era_wdata);
      else passed++;
      tick();                                                   // T+2
      csr_eentry = 32'hdeadbeef;
      total++;
      if ({csr_ex_commit, csr_ertn_commit, flush, redirect_valid} !== 4'b0010)
         $display("FAIL sys_T2_ctrl: got %b expected 0010",
                  {csr_ex_commit, csr_ertn_commit, flush, redirect_valid});
      else passed++;
      tick();                                                   // T+3
      total++;
      if ({flush, redirect_valid, busy} !== 3'b101)
         $display("FAIL sys_T3_ctrl: got %b expected 101", {flush, redirect_valid, busy});
      else passed++;
      tick();                                                   // T+4
      total++;
      if ({flush, redirect_valid, busy, csr_ex_commit} !== 4'b0110)
         $display("FAIL sys_T4_ctrl: got %b expected 0110", {flush, redirect_valid, busy, csr_ex_commit});
      else passed++;
      total++;
      if (redirect_pc !== 32'h1c008000)
         $display("FAIL sys_T4_pc: got %h expected 1c008000", redirect_pc);
      else passed++;
      redirect_ready = 1'b1;
      tick(); redirect_ready = 1'b0;                            // T+5
      total++;
      if ({busy, redirect_valid, flush} !== 3'b000)
         $display("FAIL sys_T5_idle: got %b expected 000", {busy, redirect_valid, flush});
      else passed++;
   endtask

   task automatic test_ertn;
      clear_wb();
      csr_eentry = 32'h1c008000; csr_era = 32'h1c000200;
      wb_valid = 1'b1; wb_ertn = 1'b1; wb_pc = 32'h1c000180;
      #1;
      total++;
      if (wb_cancel !== 1'b0) $display("FAIL ertn_cancel: got %b expected 0", wb_cancel);
      else passed++;
      tick(); clear_wb(); #1;
      total++;
      if ({csr_ex_commit, csr_ertn_commit, flush} !== 3'b011)
         $display("FAIL ertn_commit: got %b expected 011", {csr_ex_commit, csr_ertn_commit, flush});
      else passed++;
      tick(); tick(); tick();
      total++;
      if ({redirect_valid, redirect_pc} !== {1'b1, 32'h1c000200})
         $display("FAIL ertn_redirect: got %b/%h expected 1/1c000200", redirect_valid, redirect_pc);
      else passed++;
      redirect_ready = 1'b1;
      tick(); redirect_ready = 1'b0;
   endtask

   task automatic test_ex_and_ertn;
      clear_wb();
      csr_eentry = 32'h1c00a000; csr_era = 32'h1c000300;
      wb_valid = 1'b1; wb_ex = 1'b1; wb_ertn = 1'b1; wb_ecode = 6'h0d; wb_pc = 32'h1c000400;
      #1;
      total++;
      if (wb_cancel !== 1'b1) $display("FAIL both_cancel: got %b expected 1", wb_cancel);
      else passed++;
      tick(); clear_wb(); #1;
      total++;
      if ({csr_ex_commit, csr_ertn_commit, csr_ecode} !== {2'b10, 6'h0d})
         $display("FAIL both_commit: got %b/%h expected 10/0d", {csr_ex_commit, csr_ertn_commit}, csr_ecode);
      else passed++;
      tick(); tick(); tick();
      total++;
      if (redirect_pc !== 32'h1c00a000) $display("FAIL both_target: got %h expected 1c00a000", redirect_pc);
      else passed++;
      redirect_ready = 1'b1;
      tick(); redirect_ready = 1'b0;
   endtask

   // Backpressure in REDIRECT, then a new event in the first IDLE cycle after the handshake.
   task automatic test_back_to_back;
      clear_wb();
      redirect_ready = 1'b0;
      csr_eentry = 32'h1c00c000; csr_era = 32'h0;
      wb_valid = 1'b1; wb_ex = 1'b1; wb_ecode = 6'h0b; wb_pc = 32'h1c000500;
      tick(); clear_wb(); tick(); tick(); tick();               // now in REDIRECT
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            wb_valid = 1'b1; wb_ex = 1'b1; wb_ecode = 6'h07; wb_pc = 32'h1c000600;
            #1;
            total++;
            if (wb_cancel !== 1'b0) $display("FAIL bp_ignored_cancel: got %b expected 0", wb_cancel);
            else passed++;
         end
         total++;
         if ({redirect_valid, flush, csr_ex_commit, csr_ertn_commit, redirect_pc} !== {4'b1000, 32'h1c00c000})
            $display("FAIL bp_hold_%0d: got %b/%h expected 1000/1c00c000", i,
                     {redirect_valid, flush, csr_ex_commit, csr_ertn_commit}, redirect_pc);
         else passed++;
         tick(); clear_wb();
      end
      total++;
      if ({csr_ecode, csr_era_wdata} !== {6'h0b, 32'h1c000500})
         $display("FAIL bp_no_capture: got %h/%h expected 0b/1c000500", csr_ecode, csr_era_wdata);
      else passed++;
      redirect_ready = 1'b1;
      tick(); redirect_ready = 1'b0;                            // IDLE
      wb_valid = 1'b1; wb_ex = 1'b1; wb_ecode = 6'h0c; wb_esubcode = 9'h002; wb_pc = 32'h1c000700;
      #1;
      total++;
      if ({busy, wb_cancel} !== 2'b01) $display("FAIL b2b_accept: got %b expected 01", {busy, wb_cancel});
      else passed++;
      tick(); clear_wb(); #1;
      total++;
      if ({csr_ex_commit, csr_ecode, csr_esubcode, csr_era_wdata} !== {1'b1, 6'h0c, 9'h002, 32'h1c000700})
         $display("FAIL b2b_commit: got %b/%h/%h/%h expected 1/0c/002/1c000700",
                  csr_ex_commit, csr_ecode, csr_esubcode, csr_era_wdata);
      else passed++;
      tick(); tick(); tick();
      redirect_ready = 1'b1;
      tick(); redirect_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      clear_wb();
      csr_eentry = 32'h1c008000; csr_era = 32'h0;
      wb_valid = 1'b1; wb_ex = 1'b1; wb_ecode = 6'h0b; wb_pc = 32'h1c000800;
      tick(); clear_wb(); tick();                               // DRAIN
      reset = 1'b1;
      tick();
      total++;
      if ({csr_ex_commit, csr_ertn_commit, flush, redirect_valid, busy} !== 5'b0)
         $display("FAIL rstmid_ctrl: got %b expected 00000",
                  {csr_ex_commit, csr_ertn_commit, flush, redirect_valid, busy});
      else passed++;
      total++;
      if ({csr_ecode, csr_esubcode, csr_era_wdata, redirect_pc} !== 79'h0)
         $display("FAIL rstmid_data: got %h expected 0", {csr_ecode, csr_esubcode, csr_era_wdata, redirect_pc});
      else passed++;
      reset = 1'b0;
      wb_valid = 1'b1; wb_ex = 1'b1; wb_ecode = 6'h0b; wb_pc = 32'h1c000900;
      tick(); clear_wb(); #1;
      total++;
      if ({csr_ex_commit, flush, csr_era_wdata} !== {2'b11, 32'h1c000900})
         $display("FAIL rstmid_again: got %b/%h expected 11/1c000900", {csr_ex_commit, flush}, csr_era_wdata);
      else passed++;
      tick(); tick(); tick();
      total++;
      if ({redirect_valid, redirect_pc} !== {1'b1, 32'h1c008000})
         $display("FAIL rstmid_redirect: got %b/%h expected 1/1c008000", redirect_valid, redirect_pc);
      else passed++;
      redirect_ready = 1'b1;
      tick(); redirect_ready = 1'b0;
   endtask

   task automatic test_interrupt;
      clear_wb();
      csr_eentry = 32'h1c008000;
      wb_valid = 1'b1; int_pending = 1'b1; wb_ecode = 6'h15; wb_esubcode = 9'h033; wb_pc = 32'h1c000040;
      #1;
      total++;
      if (wb_cancel !== 1'b0) $display("FAIL int_cancel: got %b expected 0", wb_cancel);
      else passed++;
      tick(); clear_wb(); #1;
`ifdef INT_SAMPLE_EN
      total++;
      if ({csr_ex_commit, csr_ecode, csr_esubcode, csr_era_wdata} !== {1'b1, 6'h00, 9'h000, 32'h1c000044})
         $display("FAIL int_taken: got %b/%h/%h/%h expected 1/00/000/1c000044",
                  csr_ex_commit, csr_ecode, csr_esubcode, csr_era_wdata);
      else passed++;
      tick(); tick(); tick();
      redirect_ready = 1'b1;
      tick(); redirect_ready = 1'b0;
`else
      total++;
      if ({busy, csr_ex_commit, flush} !== 3'b000)
         $display("FAIL int_ignored: got %b expected 000", {busy, csr_ex_commit, flush});
      else passed++;
`endif
   endtask

   initial begin
      test_reset();
      test_syscall();
      test_ertn();
      test_ex_and_ertn();
      test_back_to_back();
      test_reset_mid();
      test_interrupt();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
